// File: rtl/modarith_sched_pkg.sv
// modarith_pkg: shared types and constants for the modular add/sub scheduler.
//   MA_W       default operand/modulus width
//   NREQ       number of requesters sharing the datapath
//   OP_ADD/SUB opcode encoding carried on req_sub
//   req_state_t per-requester IDLE/INFLIGHT/RESP state
//   stage_t    one pipeline stage: valid bit, requester tag, opcode, operands
//   modarith_calc  (a +/- b) mod m on W+1 bits
package modarith_pkg;

    localparam int   MA_W   = 256;
    localparam int   NREQ   = 2;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INFLIGHT = 2'd1,
        RESP     = 2'd2
    } req_state_t;

    typedef struct packed {
        logic            valid;
        logic            tag;
        logic            sub;
        logic [MA_W-1:0] a;
        logic [MA_W-1:0] b;
        logic [MA_W-1:0] m;
    } stage_t;

    // The extra top bit holds the carry of a+b, which matters when m is close
    // to 2^W. Subtraction wraps modulo 2^W, so adding m back after a borrow
    // lands on the right value once truncated.
    function automatic logic [MA_W-1:0] modarith_calc(input stage_t s);
        logic [MA_W:0] sum;
        logic [MA_W:0] diff;
        logic [MA_W:0] res;
        sum  = {1'b0, s.a} + {1'b0, s.b};
        diff = {1'b0, s.a} - {1'b0, s.b};
        if (s.sub == OP_SUB) begin
            res = (s.a >= s.b) ? diff : diff + {1'b0, s.m};
        end else begin
            res = (sum >= {1'b0, s.m}) ? sum - {1'b0, s.m} : sum;
        end
        return MA_W'(res);
    endfunction

endpackage

// File: rtl/modarith_sched_if.sv
// modarith_sched_if: bundle of both requesters' operation and result channels.
//   req_valid/req_ready/req_sub  per-requester handshake and opcode (bit i)
//   req_a/req_b/req_m            operands and modulus, requester i at [i*W +: W]
//   rsp_valid/rsp_ready/rsp_data per-requester result channel, same packing
// master = requester side, slave = scheduler side.
interface modarith_sched_if import modarith_pkg::*; #(
    parameter int W = MA_W
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_sub;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*W-1:0] req_m;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [NREQ*W-1:0] rsp_data;

    modport master (
        output req_valid, req_sub, req_a, req_b, req_m, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_sub, req_a, req_b, req_m, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/modarith_sched_addsub_pipe.sv
// mod_addsub_pipe: LAT-stage shift pipeline for modular add/sub.
//   clk, rst   clock and asynchronous active-high reset (clears stage valids)
//   in_stage   operation captured on the accept edge (valid, tag, op, a, b, m)
//   out_valid  final stage holds an operation
//   out_tag    requester that issued it
//   out_res    its result, computed from the final stage
module mod_addsub_pipe import modarith_pkg::*; #(
    parameter int LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  stage_t          in_stage,
    output logic            out_valid,
    output logic            out_tag,
    output logic [MA_W-1:0] out_res
);
    stage_t [LAT-1:0] st_q;
    stage_t [LAT-1:0] st_d;

    always_comb begin
        st_d[0] = in_stage;
        for (int k = 1; k < LAT; k++) begin
            st_d[k] = st_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign out_valid = st_q[LAT-1].valid;
    assign out_tag   = st_q[LAT-1].tag;
    assign out_res   = modarith_calc(st_q[LAT-1]);
endmodule

// File: rtl/modarith_sched.sv
// modarith_sched: shares one modular add/sub pipeline between two requesters.
//   clk, rst  clock and asynchronous active-high reset
//   bus       slave side of modarith_sched_if: per-requester op channel in,
//             per-requester result channel out
// Each requester has an IDLE/INFLIGHT/RESP state; only IDLE requesters can be
// granted, so each has at most one operation outstanding and its response
// register can never be overwritten. Grants are round-robin on contention.
// W must match MA_W, the width carried by the pipeline stage type.
module modarith_sched import modarith_pkg::*; #(
    parameter int W   = MA_W,
    parameter int LAT = 2
) (
    input logic              clk,
    input logic              rst,
    modarith_sched_if.slave  bus
);
    req_state_t [NREQ-1:0]        state_q, state_d;
    logic       [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
    logic       [NREQ-1:0][W-1:0] rsp_data_q, rsp_data_d;
    logic                         prio_q, prio_d;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] grant;
    logic            sel;
    stage_t          in_stage;
    logic            pipe_valid;
    logic            pipe_tag;
    logic [W-1:0]    pipe_res;

    // Arbiter: a RESP requester is not eligible, so a consume and a new
    // grant for the same requester never share a cycle.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = bus.req_valid[i] && (state_q[i] == IDLE);
        end
        grant = '0;
        if (eligible[0] && eligible[1]) begin
            grant[prio_q] = 1'b1;
        end else begin
            grant = eligible;
        end
        prio_d = prio_q;
        if (grant[0]) begin
            prio_d = 1'b1;
        end else if (grant[1]) begin
            prio_d = 1'b0;
        end
    end

    assign sel = grant[1];

    always_comb begin
        in_stage.valid = |grant;
        in_stage.tag   = sel;
        in_stage.sub   = bus.req_sub[sel];
        in_stage.a     = bus.req_a[sel*W +: W];
        in_stage.b     = bus.req_b[sel*W +: W];
        in_stage.m     = bus.req_m[sel*W +: W];
    end

    mod_addsub_pipe #(.LAT(LAT)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_stage  (in_stage),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag),
        .out_res   (pipe_res)
    );

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        for (int i = 0; i < NREQ; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (grant[i]) begin
                        state_d[i] = INFLIGHT;
                    end
                end
                INFLIGHT: begin
                    if (pipe_valid && (pipe_tag == 1'(i))) begin
                        state_d[i]     = RESP;
                        rsp_valid_d[i] = 1'b1;
                        rsp_data_d[i]  = pipe_res;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[i]) begin
                        state_d[i]     = IDLE;
                        rsp_valid_d[i] = 1'b0;
                    end
                end
                default: begin
                    state_d[i]     = IDLE;
                    rsp_valid_d[i] = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= {NREQ{IDLE}};
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            prio_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            prio_q      <= prio_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
endmodule

// File: tb/tb_modarith_sched.sv
// tb_modarith_sched: directed bench for modarith_sched with a transaction-level
// reference model (timestamped completions, plain modular arithmetic).
module tb_modarith_sched;
    import modarith_pkg::*;

    localparam int W   = MA_W;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    modarith_sched_if #(.W(W)) bus ();

    modarith_sched #(.W(W), .LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;
    bit run_cmp = 1'b0;

    // Model: 0 idle, 1 waiting for completion edge, 2 holding a result.
    int           mst    [2];
    int           done_c [2];
    logic [W-1:0] mdata  [2];
    bit           mprio;
    int           cyc = 0;

    function automatic logic [W-1:0] model_calc(bit sub, logic [W-1:0] a, logic [W-1:0] b,
                                                logic [W-1:0] m);
        logic [W+1:0] aa, bb, mm, r;
        aa = {2'b00, a};
        bb = {2'b00, b};
        mm = {2'b00, m};
        if (sub) r = (aa + mm - bb) % mm;
        else     r = (aa + bb) % mm;
        return r[W-1:0];
    endfunction

    function automatic logic [1:0] model_grant();
        logic [1:0] e;
        for (int i = 0; i < 2; i++) e[i] = bus.req_valid[i] && (mst[i] == 0);
        if (e == 2'b11) return mprio ? 2'b10 : 2'b01;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) mst[i] = 0;
            mprio = 1'b0;
        end else begin
            logic [1:0] g;
            g = model_grant();
            cyc = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                if (mst[i] == 2) begin
                    if (bus.rsp_ready[i]) mst[i] = 0;
                end else if (mst[i] == 1) begin
                    if (cyc == done_c[i]) mst[i] = 2;
                end else if (g[i]) begin
                    mst[i]    = 1;
                    done_c[i] = cyc + LAT;
                    mdata[i]  = model_calc(bus.req_sub[i], bus.req_a[i*W +: W],
                                           bus.req_b[i*W +: W], bus.req_m[i*W +: W]);
                end
            end
            if (g[0]) mprio = 1'b1;
            else if (g[1]) mprio = 1'b0;
        end
    end

    task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cmp_cycle();
        logic [1:0] g;
        g = model_grant();
        check("req_ready", W'(bus.req_ready), W'(g));
        for (int i = 0; i < 2; i++) begin
            check("rsp_valid", W'(bus.rsp_valid[i]), W'(mst[i] == 2));
            if (mst[i] == 2) check("rsp_data", bus.rsp_data[i*W +: W], mdata[i]);
        end
    endtask

    task automatic set_req(int i, bit sub, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] m);
        bus.req_sub[i]       = sub;
        bus.req_a[i*W +: W]  = a;
        bus.req_b[i*W +: W]  = b;
        bus.req_m[i*W +: W]  = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on requester i, with literal expected result.
    task automatic do_op(string name, int i, bit sub, logic [W-1:0] a, logic [W-1:0] b,
                         logic [W-1:0] m, logic [W-1:0] exp);
        bit acc = 1'b0;
        int n   = 0;
        set_req(i, sub, a, b, m);
        bus.req_valid[i] = 1'b1;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = bus.req_ready[i];
            tick();
        end
        bus.req_valid[i] = 1'b0;
        check({name, "_accept"}, W'(acc), W'(1));
        while (n < 20) begin
            tick();
            n++;
            if (bus.rsp_valid[i]) break;
        end
        check({name, "_latency"}, W'(n), W'(LAT));
        check({name, "_data"}, bus.rsp_data[i*W +: W], exp);
        $display("op %s req=%0d sub=%0d result=%h latency=%0d", name, i, sub,
                 bus.rsp_data[i*W +: W], n);
        bus.rsp_ready[i] = 1'b1;
        tick();
        bus.rsp_ready[i] = 1'b0;
        check({name, "_rsp_drop"}, W'(bus.rsp_valid[i]), W'(0));
    endtask

    task automatic drain();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        repeat (6) tick();
        bus.rsp_ready = 2'b00;
    endtask

    logic [W-1:0] bigm;
    logic [W-1:0] bigm_m1;
    logic [W-1:0] bigm_m2;

    initial begin
        logic [1:0] last_g;
        int         cnt0, cnt1, r1_served;
        bit         have_last;

        bigm    = {{31{8'hFF}}, 8'h43};
        bigm_m1 = {{31{8'hFF}}, 8'h42};
        bigm_m2 = {{31{8'hFF}}, 8'h41};
        bus.req_valid = '0;
        bus.req_sub   = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_m     = '0;
        bus.rsp_ready = '0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && run_cmp) cmp_cycle();
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", W'(bus.rsp_valid), W'(0));
        check("rst_rsp_data0", bus.rsp_data[0 +: W], '0);
        check("rst_req_ready", W'(bus.req_ready), W'(0));
        @(negedge clk);
        rst = 1'b0;
        run_cmp = 1'b1;
        tick();

        // Two simultaneous requests right after reset: requester 0 wins first
        set_req(0, OP_ADD, 5, 6, 97);
        set_req(1, OP_SUB, 10, 20, 97);
        bus.req_valid = 2'b11;
        @(negedge clk);
        check("both_first_grant", W'(bus.req_ready), W'(2'b01));
        tick();
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        check("both_second_grant", W'(bus.req_ready), W'(2'b10));
        tick();
        bus.req_valid[1] = 1'b0;
        tick();
        check("both_r0_valid", W'(bus.rsp_valid), W'(2'b01));
        check("both_r0_data", bus.rsp_data[0 +: W], W'(11));
        $display("op both r0 result=%h", bus.rsp_data[0 +: W]);
        tick();
        check("both_r1_valid", W'(bus.rsp_valid), W'(2'b11));
        check("both_r1_data", bus.rsp_data[W +: W], W'(87));
        $display("op both r1 result=%h", bus.rsp_data[W +: W]);
        bus.rsp_ready = 2'b11;
        tick();
        bus.rsp_ready = 2'b00;
        check("both_drop", W'(bus.rsp_valid), W'(0));

        // Single-requester vectors, m = 97
        do_op("sub_10_20", 0, OP_SUB, 10, 20, 97, 87);
        do_op("add_90_10", 0, OP_ADD, 90, 10, 97, 3);
        do_op("add_5_6",   0, OP_ADD, 5, 6, 97, 11);

        // Both requesters hold valid: grants must alternate
        set_req(0, OP_ADD, 40, 70, 97);
        set_req(1, OP_SUB, 3, 96, 97);
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        have_last = 1'b0;
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                if (have_last) check("rr_alternate", W'(bus.req_ready != last_g), W'(1));
                $display("grant cycle=%0d ready=%b", k, bus.req_ready);
                last_g = bus.req_ready;
                have_last = 1'b1;
                if (bus.req_ready[0]) cnt0++;
                if (bus.req_ready[1]) cnt1++;
            end
            tick();
        end
        check("rr_r0_served", W'(cnt0 >= 4), W'(1));
        check("rr_r1_served", W'(cnt1 >= 4), W'(1));
        drain();

        // Backpressure on requester 0 while requester 1 keeps working
        set_req(0, OP_ADD, 90, 10, 97);
        set_req(1, OP_ADD, 1, 2, 97);
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        check("bp_accept0", W'(bus.req_ready[0]), W'(1));
        tick();
        bus.rsp_ready[1] = 1'b1;
        bus.req_valid[1] = 1'b1;
        r1_served = 0;
        for (int k = 0; k < 10 && !bus.rsp_valid[0]; k++) tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", W'(bus.rsp_valid[0]), W'(1));
            check("bp_hold_data", bus.rsp_data[0 +: W], W'(3));
            check("bp_no_ready0", W'(bus.req_ready[0]), W'(0));
            if (bus.req_ready[1]) r1_served++;
            $display("bp cycle=%0d rsp_valid=%b ready=%b", k, bus.rsp_valid, bus.req_ready);
            tick();
        end
        check("bp_r1_served", W'(r1_served >= 1), W'(1));
        bus.req_valid[1] = 1'b0;
        repeat (6) tick();
        bus.rsp_ready[1] = 1'b0;
        bus.rsp_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_no_same_cycle", W'(bus.req_ready[0]), W'(0));
        tick();
        bus.rsp_ready[0] = 1'b0;
        @(negedge clk);
        check("bp_next_accept", W'(bus.req_ready[0]), W'(1));
        tick();
        bus.req_valid[0] = 1'b0;
        drain();

        // Reset with both requesters in flight
        set_req(0, OP_ADD, 1, 1, 97);
        set_req(1, OP_ADD, 2, 2, 97);
        bus.req_valid = 2'b11;
        tick();
        bus.req_valid[0] = 1'b0;
        tick();
        bus.req_valid[1] = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_rsp_valid", W'(bus.rsp_valid), W'(0));
        check("mid_rst_rsp_data", bus.rsp_data, '0);
        check("mid_rst_req_ready", W'(bus.req_ready), W'(0));
        $display("reset asserted mid-flight rsp_valid=%b", bus.rsp_valid);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("post_rst_no_stale", W'(bus.rsp_valid), W'(0));
        end
        do_op("fresh_after_rst", 1, OP_ADD, 50, 60, 97, 13);

        // Large modulus exercises the carry-out bit
        do_op("big_add", 0, OP_ADD, bigm_m1, bigm_m1, bigm, bigm_m2);
        do_op("big_sub", 1, OP_SUB, '0, W'(1), bigm, bigm_m1);

        repeat (3) tick();
        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
